// File: rtl/railway_xing_ctrl_if.sv
// railway_xing_ctrl_if: track sensors and operator override in, lights, gate and status out
interface railway_xing_ctrl_if #(
  parameter int NUM_TRACKS = 2,
  parameter int CNT_W      = 8
);
  logic [NUM_TRACKS-1:0] rail_detect;
  logic                  manual_close;
  logic [2:0]            light;
  logic [1:0]            gate;
  logic [2:0]            state;
  logic [CNT_W-1:0]      train_cnt;
  logic                  busy;
  modport master (output rail_detect, manual_close, input light, gate, state, train_cnt, busy);
  modport slave  (input rail_detect, manual_close, output light, gate, state, train_cnt, busy);
endinterface

// File: rtl/railway_xing_ctrl.sv
// railway_xing_ctrl: level-crossing sequencer (warn, lower, hold closed, raise) with saturating arrival counter
module railway_xing_ctrl #(
  parameter int NUM_TRACKS = 2,
  parameter int TW         = 8,
  parameter int WARN_CYC   = 4,
  parameter int LOWER_CYC  = 3,
  parameter int HOLD_CYC   = 5,
  parameter int RAISE_CYC  = 3,
  parameter int CNT_W      = 8
) (
  input logic               clk,
  input logic               reset,
  railway_xing_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, WARN = 3'd1, LOWER = 3'd2, CLOSED = 3'd3, RAISE = 3'd4} state_t;
  state_t                st, nxt;
  logic [TW-1:0]         tmr, tmr_nxt;
  logic [NUM_TRACKS-1:0] rd_q, rise;
  logic [CNT_W+3:0]      sum;
  logic                  trig, done;
  assign trig = (|bus.rail_detect) | bus.manual_close;
  assign done = tmr == '0;
  assign rise = bus.rail_detect & ~rd_q;
  assign bus.state = st;
  always_comb begin
    nxt = IDLE;
    tmr_nxt = '0;
    case (st)
      IDLE: begin
        nxt = trig ? WARN : IDLE;
        tmr_nxt = trig ? TW'(WARN_CYC - 1) : '0;
      end
      WARN: begin
        nxt = done ? LOWER : WARN;
        tmr_nxt = done ? TW'(LOWER_CYC - 1) : tmr - 1'b1;
      end
      LOWER: begin
        nxt = done ? CLOSED : LOWER;
        tmr_nxt = done ? TW'(HOLD_CYC - 1) : tmr - 1'b1;
      end
      CLOSED: begin
        nxt = (trig || !done) ? CLOSED : RAISE;
        tmr_nxt = trig ? TW'(HOLD_CYC - 1) : done ? TW'(RAISE_CYC - 1) : tmr - 1'b1;
      end
      RAISE: begin
        // any occupancy while raising re-closes the gate immediately
        nxt = trig ? LOWER : done ? IDLE : RAISE;
        tmr_nxt = trig ? TW'(LOWER_CYC - 1) : done ? '0 : tmr - 1'b1;
      end
      default: ;
    endcase
  end
  always_comb begin
    sum = {4'b0, bus.train_cnt};
    for (int i = 0; i < NUM_TRACKS; i++) sum = sum + (CNT_W + 4)'(rise[i]);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st            <= IDLE;
      tmr           <= '0;
      rd_q          <= '0;
      bus.train_cnt <= '0;
      bus.light     <= 3'b001;
      bus.gate      <= 2'b00;
      bus.busy      <= 1'b0;
    end else begin
      st            <= nxt;
      tmr           <= tmr_nxt;
      rd_q          <= bus.rail_detect;
      bus.train_cnt <= (|sum[CNT_W+3:CNT_W]) ? '1 : sum[CNT_W-1:0];
      bus.light     <= nxt == IDLE ? 3'b001 : (nxt == WARN || nxt == RAISE) ? 3'b010 : 3'b100;
      bus.gate      <= nxt == LOWER ? 2'b01 : nxt == CLOSED ? 2'b11 : nxt == RAISE ? 2'b10 : 2'b00;
      bus.busy      <= nxt != IDLE;
    end
  end
endmodule

// File: tb/tb_railway_xing_ctrl.sv
// tb_railway_xing_ctrl: directed scenario bench for the crossing controller
module tb_railway_xing_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  railway_xing_ctrl_if #(.NUM_TRACKS(2), .CNT_W(8)) bus ();
  railway_xing_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bus.rail_detect = 2'b00;
    bus.manual_close = 1'b0;
    reset = 1'b0;
    step(2);
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.state); end
    checks++; if (bus.light !== 3'b001) begin errors++; $display("FAIL reset_light got %b exp 001", bus.light); end
    checks++; if (bus.gate !== 2'b00) begin errors++; $display("FAIL reset_gate got %b exp 00", bus.gate); end
    checks++; if (bus.train_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.train_cnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    reset = 1'b1;
    step(1);
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL post_reset_idle got %0d exp 0", bus.state); end
  endtask

  task automatic test_full_cycle;
    logic [2:0] es, el;
    logic [1:0] eg;
    bus.rail_detect = 2'b01;
    for (int k = 0; k <= 15; k++) begin
      step(1);
      bus.rail_detect = 2'b00;
      es = k < 4 ? 3'd1 : k < 7 ? 3'd2 : k < 12 ? 3'd3 : k < 15 ? 3'd4 : 3'd0;
      el = es == 3'd0 ? 3'b001 : (es == 3'd1 || es == 3'd4) ? 3'b010 : 3'b100;
      eg = es == 3'd2 ? 2'b01 : es == 3'd3 ? 2'b11 : es == 3'd4 ? 2'b10 : 2'b00;
      checks++; if (bus.state !== es) begin errors++; $display("FAIL full_state E%0d got %0d exp %0d", k, bus.state, es); end
      checks++; if (bus.light !== el) begin errors++; $display("FAIL full_light E%0d got %b exp %b", k, bus.light, el); end
      checks++; if (bus.gate !== eg) begin errors++; $display("FAIL full_gate E%0d got %b exp %b", k, bus.gate, eg); end
      checks++; if (bus.busy !== (es != 3'd0)) begin errors++; $display("FAIL full_busy E%0d got %b", k, bus.busy); end
    end
    checks++; if (bus.train_cnt !== 8'd1) begin errors++; $display("FAIL full_cnt got %0d exp 1", bus.train_cnt); end
  endtask

  task automatic test_reoccupancy;
    bus.rail_detect = 2'b01;
    step(1);
    bus.rail_detect = 2'b00;
    step(13);
    checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL reocc_raise got %0d exp 4", bus.state); end
    bus.rail_detect = 2'b10;
    step(1);
    bus.rail_detect = 2'b00;
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL reocc_state got %0d exp 2", bus.state); end
    checks++; if (bus.light !== 3'b100) begin errors++; $display("FAIL reocc_light got %b exp 100", bus.light); end
    checks++; if (bus.gate !== 2'b01) begin errors++; $display("FAIL reocc_gate got %b exp 01", bus.gate); end
    step(2);
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL reocc_lower_len got %0d exp 2", bus.state); end
    step(1);
    checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL reocc_closed got %0d exp 3", bus.state); end
    checks++; if (bus.train_cnt !== 8'd3) begin errors++; $display("FAIL reocc_cnt got %0d exp 3", bus.train_cnt); end
    step(8);
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reocc_idle got %0d exp 0", bus.state); end
  endtask

  task automatic test_simultaneous;
    bus.rail_detect = 2'b11;
    step(1);
    checks++; if (bus.train_cnt !== 8'd5) begin errors++; $display("FAIL simul_cnt got %0d exp 5", bus.train_cnt); end
    bus.rail_detect = 2'b00;
    step(1);
    for (int i = 0; i < 249; i++) begin
      bus.rail_detect = 2'b01;
      step(1);
      bus.rail_detect = 2'b00;
      step(1);
    end
    checks++; if (bus.train_cnt !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d exp 254", bus.train_cnt); end
    bus.rail_detect = 2'b11;
    step(1);
    checks++; if (bus.train_cnt !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d exp 255", bus.train_cnt); end
    bus.rail_detect = 2'b00;
    step(1);
    bus.rail_detect = 2'b11;
    step(1);
    bus.rail_detect = 2'b00;
    checks++; if (bus.train_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", bus.train_cnt); end
    for (int i = 0; i < 20 && bus.state !== 3'd0; i++) step(1);
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL simul_idle_timeout got %0d exp 0", bus.state); end
  endtask

  task automatic test_hold_extension;
    bus.rail_detect = 2'b01;
    step(8);
    checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL hold_enter got %0d exp 3", bus.state); end
    step(1);
    bus.rail_detect = 2'b00;
    step(3);
    checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL hold_gap got %0d exp 3", bus.state); end
    bus.rail_detect = 2'b01;
    step(1);
    bus.rail_detect = 2'b00;
    step(4);
    checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL hold_4clear got %0d exp 3", bus.state); end
    step(1);
    checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL hold_5clear got %0d exp 4", bus.state); end
    step(3);
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL hold_idle got %0d exp 0", bus.state); end
  endtask

  task automatic test_async_abort;
    bus.rail_detect = 2'b01;
    step(9);
    checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL abort_pre got %0d exp 3", bus.state); end
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL abort_state got %0d exp 0", bus.state); end
    checks++; if (bus.light !== 3'b001) begin errors++; $display("FAIL abort_light got %b exp 001", bus.light); end
    checks++; if (bus.gate !== 2'b00) begin errors++; $display("FAIL abort_gate got %b exp 00", bus.gate); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
    checks++; if (bus.train_cnt !== 8'd0) begin errors++; $display("FAIL abort_cnt got %0d exp 0", bus.train_cnt); end
    step(2);
    reset = 1'b1;
    step(1);
    checks++; if (bus.train_cnt !== 8'd1) begin errors++; $display("FAIL first_edge_cnt got %0d exp 1", bus.train_cnt); end
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL first_edge_state got %0d exp 1", bus.state); end
    bus.rail_detect = 2'b00;
    for (int i = 0; i < 30 && bus.state !== 3'd0; i++) step(1);
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL abort_idle_timeout got %0d exp 0", bus.state); end
  endtask

  task automatic test_manual_close;
    bus.manual_close = 1'b1;
    step(40);
    checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL manual_hold got %0d exp 3", bus.state); end
    checks++; if (bus.train_cnt !== 8'd1) begin errors++; $display("FAIL manual_cnt got %0d exp 1", bus.train_cnt); end
    bus.manual_close = 1'b0;
    step(5);
    checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL manual_release got %0d exp 4", bus.state); end
    step(3);
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL manual_idle got %0d exp 0", bus.state); end
  endtask

  initial begin
    test_reset();
    test_full_cycle();
    test_reoccupancy();
    test_simultaneous();
    test_hold_extension();
    test_async_abort();
    test_manual_close();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/railway_xing_ctrl.md
RAILWAY_XING_CTRL -- requirements
Module: railway_xing_ctrl

Interface
REQ-001 Parameter NUM_TRACKS, default 2: number of independent track occupancy sensors, range 1..8.
REQ-002 Parameter TW, default 8: phase timer width in bits.
REQ-003 Parameter WARN_CYC, default 4: cycles spent in WARN, range 1..2^TW-1.
REQ-004 Parameter LOWER_CYC, default 3: cycles spent in LOWER, range 1..2^TW-1.
REQ-005 Parameter HOLD_CYC, default 5: clear-hold cycles in CLOSED after last occupancy, range 1..2^TW-1.
REQ-006 Parameter RAISE_CYC, default 3: cycles spent in RAISE, range 1..2^TW-1.
REQ-007 Parameter CNT_W, default 8: train counter width.
REQ-008 clk  input  1  single clock; all state updates on rising edge.
REQ-009 reset  input  1  asynchronous, active-low reset.
REQ-010 rail_detect  input  NUM_TRACKS  per-track occupancy level, 1 = train present.
REQ-011 manual_close  input  1  operator override, 1 = force/hold crossing closed.
REQ-012 light  output  3  one-hot signal: RED=100, YELLOW=010, GREEN=001.
REQ-013 gate  output  2  00 up, 01 lowering, 11 down, 10 raising.
REQ-014 state  output  3  current FSM state code.
REQ-015 train_cnt  output  CNT_W  count of train arrivals since reset.
REQ-016 busy  output  1  1 whenever state is not IDLE.

Function
REQ-017 FSM states and codes SHALL be IDLE=0, WARN=1, LOWER=2, CLOSED=3, RAISE=4; codes 5..7 SHALL return to IDLE on the next edge.
REQ-018 All outputs SHALL be registered and updated on the same edge as state, reflecting the new state (Moore).
REQ-019 Output decode: IDLE GREEN/00; WARN YELLOW/00; LOWER RED/01; CLOSED RED/11; RAISE YELLOW/10.
REQ-020 occ SHALL be the OR-reduction of sampled rail_detect; trig = occ | manual_close.
REQ-021 IDLE -> WARN on the edge where trig=1; otherwise remain in IDLE.
REQ-022 Entry to WARN, LOWER or RAISE SHALL load the phase timer with PARAM-1, decrement it each cycle, and leave the state on the edge where timer==0, so each of these states lasts exactly PARAM cycles.
REQ-023 WARN -> LOWER and LOWER -> CLOSED SHALL be unconditional after their timers expire; trig SHALL NOT extend or abort these states.
REQ-024 CLOSED SHALL reload the timer with HOLD_CYC-1 on every cycle where trig=1, and decrement it otherwise (no underflow below 0).
REQ-025 CLOSED -> RAISE on the edge where timer==0 and trig=0, giving exactly HOLD_CYC trig-free cycles in CLOSED.
REQ-026 RAISE -> IDLE when the timer expires with trig=0.
REQ-027 trig=1 in any RAISE cycle SHALL force RAISE -> LOWER on that edge (safety re-close), with the LOWER timer loaded with LOWER_CYC-1.
REQ-028 Arrival detect: a registered copy of rail_detect SHALL be kept, and each bit rising 0->1 SHALL count as one arrival.
REQ-029 train_cnt SHALL add the number of simultaneous rising bits in one cycle (0..NUM_TRACKS) and saturate at 2^CNT_W-1, with no wrap.
REQ-030 train_cnt SHALL update independently of FSM state; manual_close SHALL NOT count as an arrival.

Reset
REQ-031 While reset=0 (asynchronous), outputs SHALL be: state=IDLE, light=001, gate=00, busy=0, train_cnt=0, phase timer=0, registered rail_detect=0.
REQ-032 Reset asserted mid-operation, in any state, SHALL abort immediately to the REQ-031 values without completing the current phase.
REQ-033 After reset deasserts, the first edge SHALL evaluate REQ-021 normally; a track already high at that edge SHALL count as one arrival.

Verification
REQ-034 Reset check: reset=0 -> state=0, light=001, gate=00, train_cnt=0, busy=0.
REQ-035 Full cycle (defaults): rail_detect=01 for 1 cycle at edge E0 -> WARN for 4 cycles, LOWER 3, CLOSED 5, RAISE 3, then IDLE at E15; train_cnt=1.
REQ-036 Re-occupancy: rail_detect=10 in the 2nd RAISE cycle -> next state LOWER, light=100, gate=01, then CLOSED; train_cnt +1.
REQ-037 Simultaneous arrivals: rail_detect 00->11 in one cycle -> train_cnt +2; with train_cnt=254 -> train_cnt=255 (saturated), and further arrivals keep it at 255.
REQ-038 Hold extension: occupancy drops in CLOSED, then returns after 3 cycles -> CLOSED persists until 5 consecutive clear cycles; manual_close=1 holds CLOSED indefinitely with no train_cnt change.
REQ-039 Async abort: reset=0 mid-CLOSED between clock edges -> outputs reach the REQ-031 values before the next clk edge.
